// File: rtl/sa_result_collector.sv
// -----------------------------------------------------------------------------
// sa_result_collector
//
// Purpose:
//   Output-side counterpart of the systolic-array operand feeder. It collects
//   result row vectors as the array drains them, one row per I_VALID beat,
//   into a full X_R x W_C matrix register. The finished matrix is held for the
//   downstream MHA stage behind a valid/ready handshake. Rows arrive
//   bottom-first: the first accepted beat is row X_R-1 and the last is row 0.
//
// Parameters:
//   D_W  element width in bits (signed two's complement)
//   X_R  matrix rows (beats per matrix)
//   W_C  matrix columns (elements per row vector)
//
// Ports:
//   I_CLK           clock, rising edge
//   I_ASYN_RST      asynchronous active-high reset
//   I_START         arms a collection (honoured only while idle)
//   I_VALID         I_ROW_VECTOR carries a row this cycle
//   I_ROW_VECTOR    row data, element j at [j*D_W +: D_W]
//   I_ACC           (SA_COLLECT_ACC_EN only) accumulate mode, sampled with I_START
//   I_READY         downstream consumes the held matrix
//   O_BUSY          collection in progress
//   O_ROW_CNT       rows accepted in the current collection
//   O_MATRIX_VALID  matrix complete and stable
//   O_MATRIX        element (r,c) at [(r*W_C+c)*D_W +: D_W]
//
// Optional feature:
//   SA_COLLECT_ACC_EN - when defined, adds I_ACC and signed saturating
//   element-wise accumulation of incoming rows into the stored rows, for
//   K-dimension tiling across several array passes.
// -----------------------------------------------------------------------------
module sa_result_collector #(
  parameter int D_W = 16,
  parameter int X_R = 16,
  parameter int W_C = 16
) (
  input  logic                     I_CLK,
  input  logic                     I_ASYN_RST,
  input  logic                     I_START,
  input  logic                     I_VALID,
  input  logic [W_C*D_W-1:0]       I_ROW_VECTOR,
`ifdef SA_COLLECT_ACC_EN
  input  logic                     I_ACC,
`endif
  input  logic                     I_READY,
  output logic                     O_BUSY,
  output logic [15:0]              O_ROW_CNT,
  output logic                     O_MATRIX_VALID,
  output logic [X_R*W_C*D_W-1:0]   O_MATRIX
);

  localparam int ROW_W = W_C * D_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_COLLECT = 3'b010,
    S_DONE    = 3'b100
  } state_t;

  state_t                    state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [X_R*W_C*D_W-1:0]    matrix_q, matrix_d;
  logic                      accept_s;
  logic [15:0]               row_idx_s;
  logic [ROW_W-1:0]          new_row_s;

`ifdef SA_COLLECT_ACC_EN
  logic                      acc_q, acc_d;
  logic [ROW_W-1:0]          old_row_s;

  // Signed saturating add: overflow shows as disagreement of the two top
  // bits of the sign-extended sum; the extra top bit gives the true sign.
  function automatic logic [D_W-1:0] sat_add(input logic [D_W-1:0] a,
                                             input logic [D_W-1:0] b);
    logic [D_W:0] sum;
    sum = {a[D_W-1], a} + {b[D_W-1], b};
    if (sum[D_W] != sum[D_W-1]) begin
      if (sum[D_W]) begin
        sat_add = {1'b1, {(D_W-1){1'b0}}};
      end else begin
        sat_add = {1'b0, {(D_W-1){1'b1}}};
      end
    end else begin
      sat_add = sum[D_W-1:0];
    end
  endfunction
`endif

  // Bottom-first ordering: beat n lands in row X_R-1-n.
  assign row_idx_s = 16'(X_R - 1) - cnt_q;

  // Control FSM: next state, row counter and beat acceptance.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
`ifdef SA_COLLECT_ACC_EN
    acc_d    = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          state_d = S_COLLECT;
          cnt_d   = 16'd0;
`ifdef SA_COLLECT_ACC_EN
          acc_d   = I_ACC;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (I_VALID) begin
          accept_s = 1'b1;
          cnt_d    = cnt_q + 16'd1;
          if (cnt_q == 16'(X_R - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_DONE: begin
        // I_START is deliberately ignored here, even together with I_READY.
        if (I_READY) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef SA_COLLECT_ACC_EN
  // Select the stored row being targeted so only W_C adders are needed.
  always_comb begin
    old_row_s = '0;
    for (int r = 0; r < X_R; r++) begin
      if (row_idx_s == 16'(r)) begin
        old_row_s = matrix_q[r*ROW_W +: ROW_W];
      end else begin
        old_row_s = old_row_s;
      end
    end
  end

  // Row to store: saturating sum in accumulate mode, raw row otherwise.
  always_comb begin
    new_row_s = I_ROW_VECTOR;
    for (int c = 0; c < W_C; c++) begin
      if (acc_q) begin
        new_row_s[c*D_W +: D_W] = sat_add(old_row_s[c*D_W +: D_W],
                                          I_ROW_VECTOR[c*D_W +: D_W]);
      end else begin
        new_row_s[c*D_W +: D_W] = I_ROW_VECTOR[c*D_W +: D_W];
      end
    end
  end
`else
  // Rows always overwrite the stored contents.
  assign new_row_s = I_ROW_VECTOR;
`endif

  // Matrix next value: write only the row addressed by the accepted beat.
  always_comb begin
    matrix_d = matrix_q;
    for (int r = 0; r < X_R; r++) begin
      if (accept_s && (row_idx_s == 16'(r))) begin
        matrix_d[r*ROW_W +: ROW_W] = new_row_s;
      end else begin
        matrix_d[r*ROW_W +: ROW_W] = matrix_q[r*ROW_W +: ROW_W];
      end
    end
  end

  // State, counter and matrix registers with asynchronous reset.
  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      matrix_q <= '0;
`ifdef SA_COLLECT_ACC_EN
      acc_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      matrix_q <= matrix_d;
`ifdef SA_COLLECT_ACC_EN
      acc_q    <= acc_d;
`endif
    end
  end

  // Outputs are straight decodes of the one-hot state and the registers.
  assign O_BUSY         = state_q[1];
  assign O_MATRIX_VALID = state_q[2];
  assign O_ROW_CNT      = cnt_q;
  assign O_MATRIX       = matrix_q;

endmodule
